// File: rtl/mem_mgr_pkg.sv
// Shared definitions for the memory manager: allocation FSM encoding, the
// default settle delay and the block-address width used with the bitmap.
package mem_mgr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FAIL,
        ST_GRANT,
        ST_OUT
    } state_t;

    localparam int SETTLE_DEFAULT = 3;

    function automatic int addr_width(input int width, input int depth);
        return $clog2(depth) + $clog2(width);
    endfunction

endpackage

// File: rtl/mem_alloc_ctrl.sv
// Allocation/free client for the bitmap block allocator: grants blocks one at
// a time through set port 1, forwards frees to clear port 2. Optional
// statistics counters are enabled by defining MEM_ALLOC_STAT_EN.
module mem_alloc_ctrl
    import mem_mgr_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  DEPTH   = 128,
    parameter int  MAX_BLK = 8,
    parameter int  SETTLE  = SETTLE_DEFAULT,
    localparam int ADDR_W  = addr_width(WIDTH, DEPTH),
    localparam int LEN_W   = $clog2(MAX_BLK + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req_vld,
    input  logic [LEN_W-1:0]  alloc_req_len,
    output logic              alloc_req_rdy,
    output logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_addr_vld,
    output logic              alloc_addr_last,
    input  logic              alloc_addr_rdy,
    output logic              alloc_fail,
    input  logic              free_vld,
    input  logic [ADDR_W-1:0] free_addr,
    input  logic [ADDR_W-1:0] bm_emp_addr,
    input  logic              bm_emp_vld,
    input  logic [ADDR_W:0]   bm_emp_num,
    output logic              bm_wr_en_1,
    output logic [ADDR_W-1:0] bm_wr_addr_1,
    output logic              bm_wr_val_1,
    output logic              bm_wr_en_2,
    output logic [ADDR_W-1:0] bm_wr_addr_2,
    output logic              bm_wr_val_2
`ifdef MEM_ALLOC_STAT_EN
    ,
    output logic [15:0]       stat_alloc_cnt,
    output logic [15:0]       stat_free_cnt,
    output logic [15:0]       stat_fail_cnt
`endif
);

    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    state_t            state, next;
    logic [SET_W-1:0]  settle;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr_q;
    logic              free_en;
    logic [ADDR_W-1:0] free_addr_q;
    logic              grant_fire;
    logic              len_bad;
    logic              settled;

    assign settled = (settle == '0);
    assign len_bad = (len_q == '0) || (len_q > LEN_W'(MAX_BLK)) ||
                     (bm_emp_num < (ADDR_W + 1)'(len_q));

    always_comb begin
        next       = state;
        grant_fire = 1'b0;
        case (state)
            ST_IDLE:  if (alloc_req_vld) next = ST_CHECK;
            ST_CHECK: if (settled) next = len_bad ? ST_FAIL : ST_GRANT;
            ST_FAIL:  next = ST_IDLE;
            ST_GRANT: begin
                if (settled && bm_emp_vld) begin
                    grant_fire = 1'b1;
                    next       = ST_OUT;
                end
            end
            ST_OUT: begin
                if (alloc_addr_rdy)
                    next = (remaining == LEN_W'(1)) ? ST_IDLE : ST_GRANT;
            end
            default:  next = ST_IDLE;
        endcase
    end

    // Control and output registers; settle blocks trust in bitmap outputs after our own set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            settle      <= '0;
            addr_q      <= '0;
            free_en     <= 1'b0;
            free_addr_q <= '0;
        end else begin
            state   <= next;
            free_en <= free_vld;
            if (free_vld)
                free_addr_q <= free_addr;
            if (grant_fire)
                settle <= SET_W'(SETTLE);
            else if (!settled)
                settle <= settle - SET_W'(1);
            if (grant_fire)
                addr_q <= bm_emp_addr;
        end
    end

    // Request length bookkeeping; only meaningful while a request is in flight
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && alloc_req_vld)
            len_q <= alloc_req_len;
        if (state == ST_CHECK && next == ST_GRANT)
            remaining <= len_q;
        else if (state == ST_OUT && alloc_addr_rdy)
            remaining <= remaining - LEN_W'(1);
    end

    assign alloc_req_rdy   = (state == ST_IDLE);
    assign alloc_fail      = (state == ST_FAIL);
    assign alloc_addr_vld  = (state == ST_OUT);
    assign alloc_addr_last = (state == ST_OUT) && (remaining == LEN_W'(1));
    assign alloc_addr      = addr_q;
    assign bm_wr_en_1      = grant_fire;
    assign bm_wr_addr_1    = grant_fire ? bm_emp_addr : '0;
    assign bm_wr_val_1     = 1'b1;
    assign bm_wr_en_2      = free_en;
    assign bm_wr_addr_2    = free_addr_q;
    assign bm_wr_val_2     = 1'b0;

`ifdef MEM_ALLOC_STAT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alloc_cnt <= '0;
            stat_free_cnt  <= '0;
            stat_fail_cnt  <= '0;
        end else begin
            if (bm_wr_en_1) stat_alloc_cnt <= sat_inc(stat_alloc_cnt);
            if (bm_wr_en_2) stat_free_cnt  <= sat_inc(stat_free_cnt);
            if (alloc_fail) stat_fail_cnt  <= sat_inc(stat_fail_cnt);
        end
    end
`endif

endmodule
